// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM controller and its latch-cell array:
// access FSM encoding and default geometry.
package ram_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned DATA_W_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/ram_addr_decoder.sv
// Word-address to one-hot select decoder with enable; all-zero when disabled.
module ram_addr_decoder import ram_ctrl_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                      en,
  input  logic [ADDR_W-1:0]         addr,
  output logic [(1<<ADDR_W)-1:0]    sel_c
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  always_comb begin
    sel_c = '0;
    if (en) sel_c = DEPTH'(1) << addr;
  end

endmodule

// File: rtl/ram_ctrl.sv
// Sequencer for an external latch-cell RAM: each access walks
// SETUP -> STROBE -> HOLD -> DONE with every array-facing signal from a flop.
module ram_ctrl import ram_ctrl_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      wdata,
  output logic                   busy,
  output logic                   ack,
  output logic [DATA_W-1:0]      rdata,
  output logic [(1<<ADDR_W)-1:0] arr_sel,
  output logic                   arr_clk,
  output logic [DATA_W-1:0]      arr_d,
  input  logic [DATA_W-1:0]      arr_q
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_e              state;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                sel_en_c;
  logic [ADDR_W-1:0]   dec_addr_c;
  logic [DEPTH-1:0]    dec_sel_c;

  // Decode the select for the state being entered so arr_sel is a pure flop
  assign sel_en_c   = ((state == ST_IDLE) && req) || (state == ST_SETUP) ||
                      (state == ST_STROBE);
  assign dec_addr_c = (state == ST_IDLE) ? addr : addr_q;

  ram_addr_decoder #(.ADDR_W(ADDR_W)) u_dec (
    .en    (sel_en_c),
    .addr  (dec_addr_c),
    .sel_c (dec_sel_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy    <= 1'b0;
      ack     <= 1'b0;
      rdata   <= '0;
      arr_sel <= '0;
      arr_clk <= 1'b0;
      arr_d   <= '0;
    end else begin
      arr_sel <= dec_sel_c;
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            state   <= ST_SETUP;
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            busy    <= 1'b1;
            arr_d   <= wdata;
          end
        end
        ST_SETUP: begin
          state   <= ST_STROBE;
          arr_clk <= we_q;
        end
        ST_STROBE: begin
          // Falling arr_clk here is the cells' capture edge
          state   <= ST_HOLD;
          arr_clk <= 1'b0;
        end
        ST_HOLD: begin
          state <= ST_DONE;
          ack   <= 1'b1;
          if (!we_q) rdata <= arr_q;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          ack   <= 1'b0;
          busy  <= 1'b0;
          arr_d <= '0;
        end
        default: begin
          state   <= ST_IDLE;
          ack     <= 1'b0;
          busy    <= 1'b0;
          arr_clk <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl driving an 8x4 falling-edge latch-cell array model.
module tb_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       we;
  logic [2:0] addr;
  logic [3:0] wdata;
  logic       busy;
  logic       ack;
  logic [3:0] rdata;
  logic [7:0] arr_sel;
  logic       arr_clk;
  logic [3:0] arr_d;
  logic [3:0] arr_q;

  int vec  = 0;
  int errs = 0;

  logic [3:0] mem     [8];
  logic [3:0] exp_mem [8];

  // observations from the last access
  int         obs_sel_cnt, obs_sel_bad, obs_clk_cnt, obs_ack_lat, obs_ack_cnt;
  int         obs_busy_cnt, obs_d_bad;
  logic [3:0] obs_rdata;

  always #5 clk = ~clk;

  ram_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .busy    (busy),
    .ack     (ack),
    .rdata   (rdata),
    .arr_sel (arr_sel),
    .arr_clk (arr_clk),
    .arr_d   (arr_d),
    .arr_q   (arr_q)
  );

  // latch-cell array: selected words capture arr_d on the falling edge of arr_clk
  always @(negedge arr_clk) begin
    for (int i = 0; i < 8; i++)
      if (arr_sel[i]) mem[i] <= arr_d;
  end

  always_comb begin
    arr_q = '0;
    for (int i = 0; i < 8; i++)
      if (arr_sel[i]) arr_q = arr_q | mem[i];
  end

  // Issue one access and observe 8 cycles; inputs are inverted while busy.
  task automatic access(input logic w, input logic [2:0] a, input logic [3:0] d);
    logic [7:0] oh;
    oh = 8'(1) << a;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0; we = ~w; addr = ~a; wdata = ~d;
    obs_sel_cnt = 0; obs_sel_bad = 0; obs_clk_cnt = 0; obs_ack_lat = 0;
    obs_ack_cnt = 0; obs_busy_cnt = 0; obs_d_bad = 0; obs_rdata = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (arr_sel == oh) begin
        obs_sel_cnt++;
        if (arr_d != d) obs_d_bad++;
      end else if (arr_sel != 8'h00) obs_sel_bad++;
      if (arr_clk) obs_clk_cnt++;
      if (busy) obs_busy_cnt++;
      if (ack) begin
        obs_ack_cnt++;
        if (obs_ack_lat == 0) begin
          obs_ack_lat = c;
          obs_rdata   = rdata;
        end
      end
      we = ~w; addr = ~a; wdata = ~d;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    #3;
    vec++;
    if ({busy, ack, rdata, arr_sel, arr_clk, arr_d} !== 19'd0) begin
      errs++;
      $display("FAIL reset_outputs: got busy=%b ack=%b rdata=%h sel=%h clk=%b d=%h, want all 0",
               busy, ack, rdata, arr_sel, arr_clk, arr_d);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0; req = 1'b1; we = 1'b0; addr = 3'd1;
    @(posedge clk);
    #1;
    req = 1'b0;
    vec++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL first_req_after_reset: busy=%b, want 1", busy);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_fill;
    for (int i = 0; i < 8; i++) begin
      exp_mem[i] = 4'(i) ^ 4'h5;
      access(1'b1, 3'(i), exp_mem[i]);
    end
    for (int i = 0; i < 8; i++) begin
      vec++;
      if (mem[i] !== exp_mem[i]) begin
        errs++;
        $display("FAIL fill_word%0d: got %h, want %h", i, mem[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_write;
    access(1'b1, 3'd5, 4'hA);
    exp_mem[5] = 4'hA;
    vec++;
    if (obs_sel_cnt != 3 || obs_sel_bad != 0) begin
      errs++;
      $display("FAIL write_sel: sel cycles=%0d bad=%0d, want 3/0", obs_sel_cnt, obs_sel_bad);
    end
    vec++;
    if (obs_clk_cnt != 1) begin
      errs++;
      $display("FAIL write_strobe: arr_clk high %0d cycles, want 1", obs_clk_cnt);
    end
    vec++;
    if (obs_ack_lat != 4 || obs_ack_cnt != 1) begin
      errs++;
      $display("FAIL write_ack: latency=%0d count=%0d, want 4/1", obs_ack_lat, obs_ack_cnt);
    end
    vec++;
    if (obs_busy_cnt != 4 || obs_d_bad != 0) begin
      errs++;
      $display("FAIL write_busy_d: busy cycles=%0d d_bad=%0d, want 4/0", obs_busy_cnt, obs_d_bad);
    end
    for (int i = 0; i < 8; i++) begin
      vec++;
      if (mem[i] !== exp_mem[i]) begin
        errs++;
        $display("FAIL write_word%0d: got %h, want %h", i, mem[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_read_write;
    access(1'b1, 3'd0, 4'h3);
    access(1'b1, 3'd7, 4'hC);
    exp_mem[0] = 4'h3;
    exp_mem[7] = 4'hC;
    access(1'b0, 3'd7, 4'h0);
    vec++;
    if (obs_rdata !== 4'hC || obs_ack_lat != 4) begin
      errs++;
      $display("FAIL read7: rdata=%h lat=%0d, want c/4", obs_rdata, obs_ack_lat);
    end
    vec++;
    if (obs_clk_cnt != 0) begin
      errs++;
      $display("FAIL read7_strobe: arr_clk high %0d cycles, want 0", obs_clk_cnt);
    end
    access(1'b0, 3'd0, 4'hF);
    vec++;
    if (obs_rdata !== 4'h3 || obs_clk_cnt != 0) begin
      errs++;
      $display("FAIL read0: rdata=%h clk=%0d, want 3/0", obs_rdata, obs_clk_cnt);
    end
    vec++;
    if (mem[0] !== 4'h3 || mem[7] !== 4'hC) begin
      errs++;
      $display("FAIL read_no_write: word0=%h word7=%h, want 3/c", mem[0], mem[7]);
    end
    access(1'b1, 3'd6, 4'h9);
    exp_mem[6] = 4'h9;
    vec++;
    if (rdata !== 4'h3) begin
      errs++;
      $display("FAIL rdata_hold_on_write: rdata=%h, want 3", rdata);
    end
  endtask

  task automatic test_back_to_back;
    int         acks;
    int         ack_k [$];
    logic [3:0] ack_d [$];
    int         clk_hi;
    logic [3:0] want_d;
    acks = 0; clk_hi = 0;
    // req stays high; addr flips between 0 and 7 every cycle, reads only
    for (int k = 0; k <= 21; k++) begin
      @(negedge clk);
      if (k > 0) begin
        if (ack) begin
          acks++;
          ack_k.push_back(k);
          ack_d.push_back(rdata);
        end
        if (arr_clk) clk_hi++;
      end
      req = 1'b1; we = 1'b0; addr = (k % 2 == 1) ? 3'd7 : 3'd0; wdata = 4'hF;
    end
    req = 1'b0;
    repeat (6) @(negedge clk);
    vec++;
    if (acks != 4 || clk_hi != 0) begin
      errs++;
      $display("FAIL b2b_count: acks=%0d clk_hi=%0d, want 4/0", acks, clk_hi);
    end
    for (int j = 0; j < ack_k.size(); j++) begin
      want_d = (j % 2 == 0) ? 4'h3 : 4'hC;
      vec++;
      if (ack_k[j] != 4 + 5 * j || ack_d[j] !== want_d) begin
        errs++;
        $display("FAIL b2b_ack%0d: cycle=%0d rdata=%h, want %0d/%h",
                 j, ack_k[j], ack_d[j], 4 + 5 * j, want_d);
      end
    end
  endtask

  task automatic test_inputs_change;
    access(1'b1, 3'd4, 4'h9);
    exp_mem[4] = 4'h9;
    vec++;
    if (mem[4] !== 4'h9 || mem[3] !== exp_mem[3] || obs_sel_bad != 0 || obs_d_bad != 0) begin
      errs++;
      $display("FAIL inputs_change_write: word4=%h word3=%h selbad=%0d dbad=%0d, want 9/%h/0/0",
               mem[4], mem[3], obs_sel_bad, obs_d_bad, exp_mem[3]);
    end
    access(1'b0, 3'd4, 4'h0);
    vec++;
    if (obs_rdata !== 4'h9 || obs_clk_cnt != 0) begin
      errs++;
      $display("FAIL inputs_change_read: rdata=%h clk=%0d, want 9/0", obs_rdata, obs_clk_cnt);
    end
  endtask

  task automatic test_reset_strobe;
    int acks;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 3'd2; wdata = 4'h5;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(posedge clk);
    #1;
    vec++;
    if (arr_clk !== 1'b1) begin
      errs++;
      $display("FAIL strobe_before_reset: arr_clk=%b, want 1", arr_clk);
    end
    rst = 1'b1;
    #1;
    vec++;
    if ({busy, ack, rdata, arr_sel, arr_clk, arr_d} !== 19'd0) begin
      errs++;
      $display("FAIL midrun_reset: busy=%b ack=%b rdata=%h sel=%h clk=%b d=%h, want all 0",
               busy, ack, rdata, arr_sel, arr_clk, arr_d);
    end
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ack || busy) acks++;
    end
    vec++;
    if (acks != 0) begin
      errs++;
      $display("FAIL aborted_no_ack: %0d cycles with ack/busy, want 0", acks);
    end
    access(1'b0, 3'd3, 4'h0);
    vec++;
    if (obs_rdata !== exp_mem[3] || obs_ack_lat != 4) begin
      errs++;
      $display("FAIL read3_after_abort: rdata=%h lat=%0d, want %h/4", obs_rdata, obs_ack_lat, exp_mem[3]);
    end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_write;
    test_read_write;
    test_back_to_back;
    test_inputs_change;
    test_reset_strobe;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
